spdif_subframe_decoder: RTL
===========================

// Module: spdif_subframe_decoder
// PURPOSE
//  Consumes classified biphase-mark gap strobes (short/medium/long) from the S/PDIF edge stage.
//  Recognises B/M/W preambles, pairs gaps into data bits and assembles 28-bit subframes.
//  Emits 24-bit audio words with channel, block-start, V/U/C bits and a lock flag to the EQ datapath.
// PARAMETERS
//  LOCK_CNT     2    consecutive good subframes required before sync_o rises
//  TIMEOUT_CLK  64   clocks without ena_i before the decoder declares loss of signal
// PORTS
//  clk_i          in   1   system clock
//  nrst_i         in   1   asynchronous active-low reset
//  ena_i          in   1   strobe: one gap ended; class inputs valid this cycle only
//  zero_i         in   1   gap class short (1 UI)
//  one_i          in   1   gap class medium (2 UI)
//  head_i         in   1   gap class long (3 UI, preamble marker)
//  sample_o       out  24  audio word, slots 4..27, slot 4 = bit 0
//  chan_o         out  1   0 = left (B/M preamble), 1 = right (W)
//  blk_start_o    out  1   subframe began with preamble B
//  v_o/u_o/c_o    out  1   validity/user/channel-status bits of the subframe
//  valid_o        out  1   one-clock strobe: outputs above updated
//  sync_o         out  1   decoder locked
//  parity_err_o   out  1   one-clock strobe: parity failure (macro only)
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = HUNT, bit/lock/timeout counters 0, shift register 0.
//  - Gap classes are sampled only when ena_i=1. Zero or more than one class high with ena_i = INVALID gap.
//  - FSM states: HUNT, PRE1, PRE2, PRE3, DATA_A, DATA_B.
//    HUNT: ignore every gap except head -> PRE1.
//    PRE1..PRE3: capture the next 3 gap classes. After PRE3 the capture is matched:
//      B = long,short,short,long; M = long,long,short,short; W = long,medium,short,medium.
//      A match latches the preamble type, clears the bit counter and goes to DATA_A.
//      Any other sequence is an error.
//    DATA_A: medium -> shift in bit 0; short -> DATA_B; long/INVALID -> error.
//    DATA_B: short -> shift in bit 1, back to DATA_A; anything else -> error.
//    After bit 28 (slot 31) completes: subframe done. Go to PRE1 and expect head; the next gap
//      not being head is an error.
//  - Bits shift in LSB-first into a 28-bit register: [23:0] audio, [24] V, [25] U, [26] C, [27] P.
//  - Subframe done: outputs are registered on the following clock. valid_o pulses for 1 clk there,
//    only if sync_o=1 after the update. The subframe that reaches LOCK_CNT is emitted.
//    Outputs hold their value between strobes.
//  - Lock counter: increments per good subframe and saturates at LOCK_CNT. sync_o = (cnt==LOCK_CNT).
//  - Error (bad preamble, bad bit pair, INVALID gap, timeout): FSM -> HUNT, lock counter 0,
//    sync_o=0 next clk, no valid_o for the partial subframe.
//    An error whose offending gap is a head goes to PRE1 instead of HUNT, so resync is immediate.
//  - Timeout counter: clears on ena_i, else increments and saturates.
//    Reaching TIMEOUT_CLK counts as an error. In HUNT it just clears sync.
//  - Latency: ena_i of the last parity gap -> valid_o = 1 clk.
//  - nrst_i asserted mid-subframe: immediate clear. The partial subframe is discarded.
// CONFIGURATION
//  SPDIF_PARITY_CHECK_EN defined:
//    even parity checked over bits [27:0]. On failure: parity_err_o pulses (same clk valid_o would
//    have), valid_o suppressed, lock counter cleared, sync_o drops. FSM continues to PRE1, no HUNT.
//  Undefined: parity_err_o tied 0. P bit is ignored and every well-formed subframe is emitted.
// STRUCTURE
//  spdif_pkg: typedef enum gap_t {GAP_NONE,GAP_SHORT,GAP_MED,GAP_LONG},
//    typedef enum pre_t {PRE_B,PRE_M,PRE_W,PRE_BAD}, localparams SUBFRAME_BITS=28, AUDIO_W=24.
//  Sub-module spdif_preamble_match: combinational, maps three captured gap_t values to pre_t.
//  Main FSM, counters and shift register stay in this module.
// TESTING
//  1. Reset, then B preamble + 28 bits carrying audio 24'hA5A5A5, V=0,U=1,C=0, even parity, repeated
//     LOCK_CNT times -> first valid_o on 2nd subframe: sample_o=A5A5A5, blk_start_o=1, chan_o=0, sync_o=1.
//  2. Locked stream, W subframe with audio 24'h000001 -> valid_o 1 clk after last gap, chan_o=1,
//     blk_start_o=0, sample_o=000001.
//  3. Locked, inject short followed by medium inside DATA -> sync_o=0 next clk, no valid_o.
//     Next B/M/W preamble restarts lock.
//  4. Locked, stop ena_i for 64 clk -> sync_o falls at clk 64. Stream resumes -> relock after 2 subframes.
//  5. ena_i with zero_i=one_i=1 in DATA_A -> treated INVALID: error, HUNT.
//     Garbage gaps in HUNT -> no outputs change.
//  6. SPDIF_PARITY_CHECK_EN: locked, flip P bit -> parity_err_o pulse, no valid_o, sync_o=0.
//     Without the macro, same stimulus -> valid_o=1.

Source files
------------

// File: rtl/spdif_pkg.sv
// spdif_pkg: shared gap/preamble types and subframe geometry for the S/PDIF subframe decoder.
package spdif_pkg;
   localparam int SUBFRAME_BITS = 28;
   localparam int AUDIO_W       = 24;
   typedef enum logic [1:0] {GAP_NONE, GAP_SHORT, GAP_MED, GAP_LONG} gap_t;
   typedef enum logic [1:0] {PRE_B, PRE_M, PRE_W, PRE_BAD} pre_t;
endpackage

// File: rtl/spdif_preamble_match.sv
// spdif_preamble_match: maps the three gaps following a preamble's leading long gap to B/M/W.
module spdif_preamble_match
   import spdif_pkg::*;
(
   input  gap_t g1,
   input  gap_t g2,
   input  gap_t g3,
   output pre_t pre
);
   assign pre = (g1 == GAP_SHORT && g2 == GAP_SHORT && g3 == GAP_LONG)  ? PRE_B :
                (g1 == GAP_LONG  && g2 == GAP_SHORT && g3 == GAP_SHORT) ? PRE_M :
                (g1 == GAP_MED   && g2 == GAP_SHORT && g3 == GAP_MED)   ? PRE_W : PRE_BAD;
endmodule

// File: rtl/spdif_subframe_decoder.sv
// spdif_subframe_decoder: classified biphase gaps to 24-bit audio subframes with lock tracking.
// Define SPDIF_PARITY_CHECK_EN to check even parity and drop failing subframes.
module spdif_subframe_decoder
   import spdif_pkg::*;
#(
   parameter int LOCK_CNT    = 2,
   parameter int TIMEOUT_CLK = 64
) (
   input  logic               clk_i,
   input  logic               nrst_i,
   input  logic               ena_i,
   input  logic               zero_i,
   input  logic               one_i,
   input  logic               head_i,
   output logic [AUDIO_W-1:0] sample_o,
   output logic               chan_o,
   output logic               blk_start_o,
   output logic               v_o,
   output logic               u_o,
   output logic               c_o,
   output logic               valid_o,
   output logic               sync_o,
   output logic               parity_err_o
);
   localparam int LW = $clog2(LOCK_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CLK + 1);
   typedef enum logic [2:0] {HUNT, PRE1, PRE2, PRE3, DATA_A, DATA_B} state_t;
   state_t state;
   gap_t gap, cap1, cap2;
   pre_t pre_cur, pre_typ;
   logic need_head, shift, done, tout, bad, perr, emit;
   logic [4:0] bcnt;
   logic [SUBFRAME_BITS-2:0] sr;
   logic [SUBFRAME_BITS-1:0] word;
   logic [LW-1:0] lock, lock_nxt;
   logic [TW-1:0] tcnt;

   assign gap = ({head_i, one_i, zero_i} == 3'b001) ? GAP_SHORT :
                ({head_i, one_i, zero_i} == 3'b010) ? GAP_MED :
                ({head_i, one_i, zero_i} == 3'b100) ? GAP_LONG : GAP_NONE;

   spdif_preamble_match u_match (.g1(cap1), .g2(cap2), .g3(gap), .pre(pre_cur));

   always_comb begin
      bad = 1'b0;
      if (ena_i)
         case (state)
            PRE1:    bad = need_head ? gap != GAP_LONG : gap == GAP_NONE;
            PRE2:    bad = gap == GAP_NONE;
            PRE3:    bad = pre_cur == PRE_BAD;
            DATA_A:  bad = gap != GAP_MED && gap != GAP_SHORT;
            DATA_B:  bad = gap != GAP_SHORT;
            default: bad = 1'b0;
         endcase
   end

   // a bit completes on a medium gap in DATA_A (0) or the second short gap in DATA_B (1)
   assign shift = ena_i && !bad && (state == DATA_A ? gap == GAP_MED : state == DATA_B);
   assign word  = {state == DATA_B, sr};
   assign done  = shift && bcnt == 5'(SUBFRAME_BITS - 1);
   assign tout  = !ena_i && tcnt == TW'(TIMEOUT_CLK - 1);
`ifdef SPDIF_PARITY_CHECK_EN
   assign perr = ^word;
`else
   assign perr = 1'b0;
`endif
   assign lock_nxt = perr ? '0 : lock == LW'(LOCK_CNT) ? lock : lock + 1'b1;
   assign emit     = !perr && lock_nxt == LW'(LOCK_CNT);
   assign sync_o   = lock == LW'(LOCK_CNT);

   always_ff @(posedge clk_i or negedge nrst_i)
      if (!nrst_i) begin
         state        <= HUNT;
         need_head    <= 1'b0;
         cap1         <= GAP_NONE;
         cap2         <= GAP_NONE;
         pre_typ      <= PRE_B;
         bcnt         <= '0;
         sr           <= '0;
         lock         <= '0;
         tcnt         <= '0;
         sample_o     <= '0;
         chan_o       <= 1'b0;
         blk_start_o  <= 1'b0;
         v_o          <= 1'b0;
         u_o          <= 1'b0;
         c_o          <= 1'b0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
      end else begin
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         tcnt         <= ena_i ? '0 : tcnt == TW'(TIMEOUT_CLK) ? tcnt : tcnt + 1'b1;
         if (tout) begin
            state <= HUNT;
            lock  <= '0;
         end else if (bad) begin
            // a long offending gap is itself a preamble start, so resync without hunting
            state     <= gap == GAP_LONG ? PRE1 : HUNT;
            need_head <= 1'b0;
            lock      <= '0;
         end else if (ena_i)
            case (state)
               HUNT: if (gap == GAP_LONG) begin
                  state     <= PRE1;
                  need_head <= 1'b0;
               end
               PRE1: begin
                  need_head <= 1'b0;
                  if (!need_head) begin
                     cap1  <= gap;
                     state <= PRE2;
                  end
               end
               PRE2: begin
                  cap2  <= gap;
                  state <= PRE3;
               end
               PRE3: begin
                  pre_typ <= pre_cur;
                  bcnt    <= '0;
                  state   <= DATA_A;
               end
               DATA_A:  state <= gap == GAP_SHORT ? DATA_B : DATA_A;
               DATA_B:  state <= DATA_A;
               default: state <= HUNT;
            endcase
         if (shift) begin
            sr   <= word[SUBFRAME_BITS-1:1];
            bcnt <= bcnt + 1'b1;
         end
         if (done) begin
            state        <= PRE1;
            need_head    <= 1'b1;
            bcnt         <= '0;
            lock         <= lock_nxt;
            valid_o      <= emit;
            parity_err_o <= perr;
            if (emit) begin
               sample_o    <= word[AUDIO_W-1:0];
               v_o         <= word[24];
               u_o         <= word[25];
               c_o         <= word[26];
               chan_o      <= pre_typ == PRE_W;
               blk_start_o <= pre_typ == PRE_B;
            end
         end
      end
endmodule
